adder_issue_scheduler: RTL and testbench
========================================

// Module: adder_issue_scheduler
// PURPOSE
//  Picks one ready reservation-station (RS) entry per issue and dispatches its operands to the
//  single shared integer adder unit (start / SrcA / SrcB / Tag_in interface).
//  Sits between the adder RS bank and the adder FU. Keeps the FU single-occupancy: a new op
//  is not issued until the FU signals release.
//  Arbitration is round-robin across entries, so no entry can starve.
// PARAMETERS
//  NUM_RS    3   number of adder RS entries (2..8)
//  DATA_W    32  operand width
//  TAG_W     4   RS tag width
//  TAG_BASE  1   tag of entry 0; entry i carries tag TAG_BASE+i (no overflow allowed within TAG_W)
//  CNT_W     16  width of the issue counter
// PORTS
//  clk          in   1              clock
//  reset        in   1              asynchronous, active-high
//  rs_ready     in   NUM_RS         entry i busy with both operands valid
//  rs_vj        in   NUM_RS*DATA_W  entry i operand A at bits [i*DATA_W +: DATA_W]
//  rs_vk        in   NUM_RS*DATA_W  entry i operand B, same packing
//  fu_release   in   1              1-cycle pulse from FU: result consumed, FU free
//  fu_start     out  1              1-cycle issue pulse to FU
//  fu_src_a     out  DATA_W         operand A, held until next issue
//  fu_src_b     out  DATA_W         operand B, held until next issue
//  fu_tag       out  TAG_W          tag of issued entry, held until next issue
//  rs_grant     out  NUM_RS         one-hot, pulses with fu_start; RS marks the entry executing
//  fu_busy      out  1              1 from issue until release
//  issue_count  out  CNT_W          total issues since reset, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset values:
//   - All outputs 0; state IDLE; rr_ptr=0; dispatched mask=0.
//  FSM states:
//   - IDLE: FU free.
//   - BUSY: FU holds an op.
//  Eligibility:
//   - eligible[i] = rs_ready[i] & ~dispatched[i].
//  Selection:
//   - Combinational. First eligible index scanning rr_ptr, rr_ptr+1, ... modulo NUM_RS.
//  Issue condition:
//   - (state==IDLE, or state==BUSY with fu_release=1) and any eligible.
//  Issue cycle T (condition true at edge T):
//   - At T+1: fu_start=1, rs_grant=1<<sel, fu_src_a/b=vj/vk[sel], fu_tag=TAG_BASE+sel.
//   - At T+1: dispatched[sel]=1, rr_ptr=(sel+1)%NUM_RS, issue_count+1, state=BUSY, fu_busy=1.
//   - Latency from ready to fu_start is 1 cycle.
//  Start and grant width:
//   - fu_start and rs_grant are 1 cycle wide and clear automatically the next cycle.
//  No issue in BUSY:
//   - A BUSY cycle with fu_release=0 never issues.
//  Release with nothing eligible:
//   - fu_release=1 in BUSY with no eligible entry: state=IDLE, fu_busy=0 next cycle.
//  Back-to-back issue:
//   - Release and eligible in the same cycle issues at the next edge; the FU sees no idle cycle.
//  fu_release while IDLE:
//   - Ignored; no state change.
//  Dispatched mask:
//   - dispatched[i] clears any cycle rs_ready[i]=0, i.e. the entry was freed or reallocated.
//   - This prevents re-issuing an entry whose ready flag stays high until it is freed by the CDB.
//  Ready drop on the selection cycle:
//   - rs_ready[i] falling in the same cycle it would be selected: the entry is not eligible
//     and is not issued.
//  Reset during BUSY:
//   - Immediate return to reset values.
//   - Any in-flight FU op is the FU's own reset's concern.
//  Operand capture:
//   - Operands are sampled only in the issue cycle. Later changes to rs_vj/rs_vk do not
//     affect fu_src_a/b.
// STRUCTURE
//  Package adder_sched_pkg:
//   - typedef enum logic {IDLE, BUSY} sched_state_t.
//   - Default widths DATA_W/TAG_W.
//  Sub-module rr_picker:
//   - Parameterised round-robin one-hot selector (req, ptr -> gnt, idx, any).
//   - Reused later by the CDB arbiter.
//  Top level:
//   - FSM, dispatched mask, output registers and counter.
// TESTING
//  T1 Single entry issue:
//   - Stimulus: entry 1 ready, vj=5, vk=7.
//   - Next cycle: fu_start=1, src_a=5, src_b=7, fu_tag=2, rs_grant=3'b010, fu_busy=1.
//  T2 Round-robin fairness:
//   - Stimulus: all 3 ready; release pulsed 3 cycles after each issue; each entry deasserts
//     ready after its grant.
//   - Grant order: 0, 1, 2; issue_count=3.
//  T3 No issue while BUSY:
//   - Stimulus: entry 0 issued; entry 2 becomes ready while BUSY, no release for 10 cycles.
//   - fu_start stays 0 for those cycles.
//   - Release pulse -> entry 2 issued on the next cycle.
//  T4 Back-to-back issue:
//   - Stimulus: release in the same cycle another entry is eligible.
//   - fu_start at the following cycle; fu_busy never drops.
//  T5 Dispatched mask:
//   - Stimulus: entry 0 ready held high for 8 cycles after its issue and release.
//   - No second issue while held high.
//   - Drop ready 1 cycle, raise again with new operands -> reissued with the new operands.
//  T6 Reset mid-operation:
//   - Stimulus: assert reset while BUSY.
//   - Outputs 0 immediately, issue_count=0.
//   - After release of reset, a ready entry issues within 1 cycle.

Source files
------------

// File: rtl/adder_sched_pkg.sv
// Shared types and defaults for the adder issue scheduler and its helpers.
package adder_sched_pkg;

  // FU occupancy state seen by the scheduler.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sched_state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_TAG_W  = 4;

  // Index following idx in a ring of n entries.
  function automatic int rr_next(input int idx, input int n);
    if (idx + 1 >= n) begin
      return 0;
    end else begin
      return idx + 1;
    end
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin one-hot selector: first set request at or after ptr, wrapping.
module rr_picker #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan req starting at ptr and take the first requester found.
  always_comb begin
    int pos;
    logic [IDX_W-1:0] pidx;
    gnt  = {N{1'b0}};
    idx  = {IDX_W{1'b0}};
    any  = 1'b0;
    pos  = 0;
    pidx = {IDX_W{1'b0}};
    for (int k = 0; k < N; k++) begin
      pos  = (int'(ptr) + k) % N;
      pidx = IDX_W'(pos);
      if (!any && req[pidx]) begin
        any       = 1'b1;
        idx       = pidx;
        gnt[pidx] = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/adder_issue_scheduler.sv
// Issues one ready adder RS entry at a time to the shared adder FU,
// round-robin across entries, holding off while the FU is occupied.
module adder_issue_scheduler
  import adder_sched_pkg::*;
#(
  parameter int NUM_RS   = 3,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int TAG_W    = DEF_TAG_W,
  parameter int TAG_BASE = 1,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RS-1:0]        rs_ready,
  input  logic [NUM_RS*DATA_W-1:0] rs_vj,
  input  logic [NUM_RS*DATA_W-1:0] rs_vk,
  input  logic                     fu_release,
  output logic                     fu_start,
  output logic [DATA_W-1:0]        fu_src_a,
  output logic [DATA_W-1:0]        fu_src_b,
  output logic [TAG_W-1:0]         fu_tag,
  output logic [NUM_RS-1:0]        rs_grant,
  output logic                     fu_busy,
  output logic [CNT_W-1:0]         issue_count
);

  localparam int IDX_W = $clog2(NUM_RS);

  sched_state_t      state;
  sched_state_t      state_next;
  logic [NUM_RS-1:0] dispatched;
  logic [NUM_RS-1:0] dispatched_next;
  logic [NUM_RS-1:0] eligible;
  logic [NUM_RS-1:0] pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  rr_ptr_next;
  logic              pick_any;
  logic              issue;

  // An entry already sent to the FU stays ineligible until its ready drops.
  assign eligible = rs_ready & ~dispatched;

  rr_picker #(
    .N     (NUM_RS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req (eligible),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Next state and issue decision: issue when the FU is free or being freed now.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          issue      = 1'b1;
          state_next = BUSY;
        end else begin
          state_next = IDLE;
        end
      end
      BUSY: begin
        if (fu_release) begin
          if (pick_any) begin
            issue      = 1'b1;
            state_next = BUSY;
          end else begin
            state_next = IDLE;
          end
        end else begin
          state_next = BUSY;
        end
      end
      default: begin
        issue      = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Dispatched mask: set on grant, cleared whenever the entry's ready is low.
  always_comb begin
    dispatched_next = dispatched;
    for (int i = 0; i < NUM_RS; i++) begin
      if (!rs_ready[i]) begin
        dispatched_next[i] = 1'b0;
      end else if (issue && pick_gnt[i]) begin
        dispatched_next[i] = 1'b1;
      end else begin
        dispatched_next[i] = dispatched[i];
      end
    end
  end

  // Pointer moves to the entry after the one just granted.
  always_comb begin
    if (issue) begin
      rr_ptr_next = IDX_W'(rr_next(int'(pick_idx), NUM_RS));
    end else begin
      rr_ptr_next = rr_ptr;
    end
  end

  // State, mask, pointer, counter and all FU-facing output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      dispatched  <= {NUM_RS{1'b0}};
      rr_ptr      <= {IDX_W{1'b0}};
      fu_start    <= 1'b0;
      rs_grant    <= {NUM_RS{1'b0}};
      fu_src_a    <= {DATA_W{1'b0}};
      fu_src_b    <= {DATA_W{1'b0}};
      fu_tag      <= {TAG_W{1'b0}};
      fu_busy     <= 1'b0;
      issue_count <= {CNT_W{1'b0}};
    end else begin
      state      <= state_next;
      dispatched <= dispatched_next;
      rr_ptr     <= rr_ptr_next;
      fu_start   <= issue;
      rs_grant   <= issue ? pick_gnt : {NUM_RS{1'b0}};
      fu_busy    <= (state_next == BUSY);
      if (issue) begin
        fu_src_a    <= rs_vj[int'(pick_idx)*DATA_W +: DATA_W];
        fu_src_b    <= rs_vk[int'(pick_idx)*DATA_W +: DATA_W];
        fu_tag      <= TAG_W'(TAG_BASE) + TAG_W'(pick_idx);
        issue_count <= issue_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_adder_issue_scheduler.sv
// Self-checking bench for adder_issue_scheduler: directed scenarios plus a
// randomized phase, all compared against a behavioural model of the issue rules.
module tb_adder_issue_scheduler;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int TB = 1;

  logic            clk;
  logic            reset;
  logic [N-1:0]    rs_ready;
  logic [N*DW-1:0] rs_vj;
  logic [N*DW-1:0] rs_vk;
  logic            fu_release;
  logic            fu_start;
  logic [DW-1:0]   fu_src_a;
  logic [DW-1:0]   fu_src_b;
  logic [TW-1:0]   fu_tag;
  logic [N-1:0]    rs_grant;
  logic            fu_busy;
  logic [15:0]     issue_count;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit          m_busy;
  bit          m_disp [N];
  int          m_ptr;
  int          m_cnt;
  logic        e_start;
  logic [N-1:0] e_grant;
  logic [DW-1:0] e_a;
  logic [DW-1:0] e_b;
  logic [TW-1:0] e_tag;

  logic [N-1:0] grants [3];

  adder_issue_scheduler #(
    .NUM_RS(N), .DATA_W(DW), .TAG_W(TW), .TAG_BASE(TB), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .rs_ready(rs_ready), .rs_vj(rs_vj), .rs_vk(rs_vk),
    .fu_release(fu_release), .fu_start(fu_start), .fu_src_a(fu_src_a),
    .fu_src_b(fu_src_b), .fu_tag(fu_tag), .rs_grant(rs_grant), .fu_busy(fu_busy),
    .issue_count(issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    for (int i = 0; i < N; i++) m_disp[i] = 1'b0;
    m_ptr = 0; m_cnt = 0;
    e_start = 1'b0; e_grant = '0; e_a = '0; e_b = '0; e_tag = '0;
  endtask

  // Applies the issue rules to the inputs present just before the clock edge.
  task automatic model_step();
    int sel;
    bit can;
    sel = -1;
    can = !m_busy || fu_release;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (sel < 0 && rs_ready[j] && !m_disp[j]) sel = j;
    end
    for (int i = 0; i < N; i++) if (!rs_ready[i]) m_disp[i] = 1'b0;
    e_start = 1'b0;
    e_grant = '0;
    if (can && sel >= 0) begin
      e_start = 1'b1;
      e_grant = N'(1 << sel);
      e_a     = rs_vj[sel*DW +: DW];
      e_b     = rs_vk[sel*DW +: DW];
      e_tag   = TW'(TB + sel);
      m_disp[sel] = 1'b1;
      m_ptr   = (sel + 1) % N;
      m_cnt   = (m_cnt + 1) % 65536;
      m_busy  = 1'b1;
    end else if (m_busy && fu_release) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".start"}, 64'(fu_start), 64'(e_start));
    chk({ph, ".grant"}, 64'(rs_grant), 64'(e_grant));
    chk({ph, ".busy"},  64'(fu_busy),  64'(m_busy));
    chk({ph, ".count"}, 64'(issue_count), 64'(m_cnt));
    chk({ph, ".src_a"}, 64'(fu_src_a), 64'(e_a));
    chk({ph, ".src_b"}, 64'(fu_src_b), 64'(e_b));
    chk({ph, ".tag"},   64'(fu_tag),   64'(e_tag));
  endtask

  task automatic cycle(input string ph);
    model_step();
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic apply_reset(input string ph);
    reset = 1'b1;
    #1;
    model_reset();
    check_all({ph, ".rst"});
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic void set_ops(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    rs_vj[i*DW +: DW] = a;
    rs_vk[i*DW +: DW] = b;
  endfunction

  initial begin
    reset = 1'b1; rs_ready = '0; rs_vj = '0; rs_vk = '0; fu_release = 1'b0;
    #2;
    apply_reset("init");

    // T1: single entry issue
    set_ops(1, 32'd5, 32'd7);
    rs_ready = 3'b010;
    cycle("t1");
    chk("t1.start", 64'(fu_start), 64'd1);
    chk("t1.src_a", 64'(fu_src_a), 64'd5);
    chk("t1.src_b", 64'(fu_src_b), 64'd7);
    chk("t1.tag",   64'(fu_tag),   64'd2);
    chk("t1.grant", 64'(rs_grant), 64'b010);
    chk("t1.busy",  64'(fu_busy),  64'd1);
    rs_ready = 3'b000;
    cycle("t1");
    fu_release = 1'b1;
    cycle("t1");
    fu_release = 1'b0;
    chk("t1.idle", 64'(fu_busy), 64'd0);

    // T2: round-robin fairness from reset
    apply_reset("t2");
    for (int i = 0; i < N; i++) set_ops(i, $urandom, $urandom);
    rs_ready = 3'b111;
    for (int n = 0; n < 3; n++) begin
      cycle("t2");
      fu_release = 1'b0;
      grants[n] = rs_grant;
      rs_ready = rs_ready & ~rs_grant;
      cycle("t2");
      cycle("t2");
      fu_release = 1'b1;
    end
    cycle("t2");
    fu_release = 1'b0;
    chk("t2.g0", 64'(grants[0]), 64'b001);
    chk("t2.g1", 64'(grants[1]), 64'b010);
    chk("t2.g2", 64'(grants[2]), 64'b100);
    chk("t2.count", 64'(issue_count), 64'd3);

    // T3: no issue while busy, then release
    apply_reset("t3");
    set_ops(0, $urandom, $urandom);
    set_ops(2, $urandom, $urandom);
    rs_ready = 3'b001;
    cycle("t3");
    rs_ready = 3'b100;
    for (int n = 0; n < 10; n++) begin
      cycle("t3");
      chk("t3.hold", 64'(fu_start), 64'd0);
    end
    fu_release = 1'b1;
    cycle("t3");
    fu_release = 1'b0;
    chk("t3.grant", 64'(rs_grant), 64'b100);
    chk("t3.tag",   64'(fu_tag),   64'd3);

    // T4: back-to-back issue on release
    set_ops(1, $urandom, $urandom);
    rs_ready = 3'b010;
    cycle("t4");
    chk("t4.busy_pre", 64'(fu_busy), 64'd1);
    fu_release = 1'b1;
    cycle("t4");
    fu_release = 1'b0;
    chk("t4.start", 64'(fu_start), 64'd1);
    chk("t4.grant", 64'(rs_grant), 64'b010);
    chk("t4.busy",  64'(fu_busy),  64'd1);

    // T5: dispatched mask prevents reissue until ready drops
    apply_reset("t5");
    set_ops(0, 32'h11, 32'h22);
    rs_ready = 3'b001;
    cycle("t5");
    fu_release = 1'b1;
    cycle("t5");
    fu_release = 1'b0;
    for (int n = 0; n < 8; n++) begin
      cycle("t5");
      chk("t5.noreissue", 64'(fu_start), 64'd0);
    end
    rs_ready = 3'b000;
    cycle("t5");
    rs_ready = 3'b001;
    set_ops(0, 32'h33, 32'h44);
    cycle("t5");
    chk("t5.start", 64'(fu_start), 64'd1);
    chk("t5.src_a", 64'(fu_src_a), 64'h33);
    chk("t5.src_b", 64'(fu_src_b), 64'h44);
    set_ops(0, 32'h55, 32'h66);
    cycle("t5");
    chk("t5.capture", 64'(fu_src_a), 64'h33);

    // Randomized phase against the model
    for (int n = 0; n < 400; n++) begin
      rs_ready   = N'($urandom_range(0, 7));
      fu_release = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) set_ops(i, $urandom, $urandom);
      cycle("rand");
    end
    fu_release = 1'b0;

    // T6: reset while busy
    apply_reset("t6a");
    set_ops(0, $urandom, $urandom);
    rs_ready = 3'b001;
    cycle("t6");
    chk("t6.busy", 64'(fu_busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("t6.rst_busy",  64'(fu_busy),     64'd0);
    chk("t6.rst_count", 64'(issue_count), 64'd0);
    chk("t6.rst_start", 64'(fu_start),    64'd0);
    check_all("t6.rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle("t6");
    chk("t6.reissue", 64'(fu_start), 64'd1);
    chk("t6.count",   64'(issue_count), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
